pipe_reg_m: RTL and testbench
=============================

// Module: pipe_reg_m
// PURPOSE
//  E->M pipeline register of the P7 five-stage MIPS microsystem: latches E-stage results into M.
//  Feeds Res_M/A3_M to the M->W register and exposes Tnew_M for forwarding/stall control.
//  Decodes M-stage memory access: AdEL/AdES checks, byte enables, aligned store data.
//  Exception info goes to CP0; flush comes from CP0 (exception entry or ERET).
// PARAMETERS
//  DM_HI   32'h0000_2FFF  last valid DM byte address (DM starts at 0)
//  TC0_LO  32'h0000_7F00  timer0 base; window TC0_LO..TC0_LO+11
//  TC1_LO  32'h0000_7F10  timer1 base; window TC1_LO..TC1_LO+11
// PORTS
//  clk        in   1   pipeline clock, rising edge
//  reset      in   1   synchronous, active-high
//  en         in   1   1: load E values; 0: hold all registers
//  flush      in   1   insert bubble (CP0 exception/ERET)
//  Instr_E    in   32  instruction word
//  PC_E       in   32  instruction PC
//  ALUOut_E   in   32  ALU result / memory address
//  RTData_E   in   32  forwarded rt value (store data)
//  Res_E      in   3   result-source code
//  A3_E       in   5   destination GPR
//  Tnew_E     in   2   cycles until result ready, E-stage view
//  MemOp_E    in   4   memory op code
//  ExcCode_E  in   5   exception from earlier stages (0 = none)
//  BD_E       in   1   instruction is in a branch delay slot
//  Instr_M, PC_M, ALUOut_M, RTData_M  out 32 each  registered copies
//  Res_M out 3, A3_M out 5, MemOp_M out 4, BD_M out 1  registered copies
//  Tnew_M     out  2   decremented Tnew
//  ExcCode_M  out  5   final M-stage exception code
//  BE_M       out  4   DM/bridge byte enables (store only)
//  WData_M    out  32  lane-replicated store data
// BEHAVIOUR
//  Priority per edge: reset > flush > en > hold.
//  reset: every register 0. All outputs are then 0, including BE_M, WData_M and ExcCode_M.
//  flush: PC_M<=PC_E. All other registers 0 (NOP bubble: Res=RES_NW, A3=0, MemOp=MOP_NONE).
//  en=1: all fields load. Tnew_M <= (Tnew_E==0) ? 0 : Tnew_E-1 (saturating, no wrap).
//  en=0: all registers hold, including Tnew_M (no decrement while held).
//  The register has latency 1. All decode below is combinational from the M registers.
//  ExcCode_M when ExcCode_reg != 0: pass ExcCode_reg unchanged (earlier stage wins).
//  Otherwise a = ALUOut_M and ExcCode_M is decided as follows:
//   load (LW,LH,LHU,LB,LBU) -> AdEL(4) if:
//    - misaligned (LW: a[1:0]!=0; LH/LHU: a[0]!=0), or
//    - out of range (a > DM_HI and a not in either timer window), or
//    - LH/LHU/LB/LBU inside a timer window.
//   store (SW,SH,SB) -> AdES(5) if:
//    - same alignment/range rules, or
//    - SH/SB inside a timer window, or
//    - store to a timer COUNT word (base+8).
//   none/other -> 0.
//  Range test uses full 32-bit unsigned compare, so negative/wrapped addresses fail.
//  BE_M is 0 unless MemOp_M is a store and ExcCode_M==0:
//   SW: 4'b1111
//   SH: a[1] ? 4'b1100 : 4'b0011
//   SB: 4'b0001 << a[1:0]
//  WData_M:
//   SW: RTData
//   SH: {2{RTData[15:0]}}
//   SB: {4{RTData[7:0]}}
//   otherwise RTData_M.
// STRUCTURE
//  Shared package mips_defs:
//   RES_NW=0, RES_ALU=1, RES_DM=2, RES_PC=3, RES_MD=4
//   MOP_NONE=0, LW=1, LH=2, LHU=3, LB=4, LBU=5, SW=6, SH=7, SB=8
//   EXC_ADEL=4, EXC_ADES=5
//  One sub-module: mem_addr_check (combinational; MemOp + address -> ExcCode, BE, WData).
//  The rest is the register bank in this module.
// TESTING
//  1. reset=1 for 1 edge with nonzero inputs -> every output 0, ExcCode_M=0.
//  2. en=1, SW, ALUOut_E=0x1004, RTData_E=0xDEADBEEF, Tnew_E=2 -> next cycle BE_M=1111,
//     WData_M=DEADBEEF, Tnew_M=1, ExcCode_M=0.
//  3. LW at 0x1002 -> ExcCode_M=4, BE_M=0. SH at 0x3000 -> ExcCode_M=5.
//     SW at 0x7F08 -> 5. LW at 0x7F14 -> 0.
//  4. SB at 0x0103, RTData=0x12345678 -> BE_M=1000, WData_M=78787878.
//     Same with ExcCode_E=10 -> ExcCode_M=10, BE_M=0.
//  5. flush and en=1 same edge, PC_E=0x3008 -> Res_M=0, A3_M=0, Instr_M=0, PC_M=0x3008.
//     reset and flush same edge -> PC_M=0.
//  6. en=0 for 3 cycles after load with Tnew=1 -> all outputs frozen, Tnew_M stays 1.
//     Then Tnew_E=0 with en=1 -> Tnew_M=0.

Source files
------------

// File: rtl/mips_defs.sv
// Shared MIPS P7 encodings: result sources, memory op codes, exception codes and
// the default data-memory / timer address map.
package mips_defs;

  localparam logic [2:0] RES_NW  = 3'd0;
  localparam logic [2:0] RES_ALU = 3'd1;
  localparam logic [2:0] RES_DM  = 3'd2;
  localparam logic [2:0] RES_PC  = 3'd3;
  localparam logic [2:0] RES_MD  = 3'd4;

  localparam logic [3:0] MOP_NONE = 4'd0;
  localparam logic [3:0] MOP_LW   = 4'd1;
  localparam logic [3:0] MOP_LH   = 4'd2;
  localparam logic [3:0] MOP_LHU  = 4'd3;
  localparam logic [3:0] MOP_LB   = 4'd4;
  localparam logic [3:0] MOP_LBU  = 4'd5;
  localparam logic [3:0] MOP_SW   = 4'd6;
  localparam logic [3:0] MOP_SH   = 4'd7;
  localparam logic [3:0] MOP_SB   = 4'd8;

  localparam logic [4:0] EXC_NONE = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;

  localparam logic [31:0] DM_HI_DEF  = 32'h0000_2FFF;
  localparam logic [31:0] TC0_LO_DEF = 32'h0000_7F00;
  localparam logic [31:0] TC1_LO_DEF = 32'h0000_7F10;

  // Tnew counts down toward "result available"; it never wraps below zero.
  function automatic logic [1:0] tnew_step(input logic [1:0] t);
    return (t == 2'd0) ? 2'd0 : t - 2'd1;
  endfunction

  // A timer occupies three 32-bit words: lo .. lo+11.
  function automatic logic in_window(input logic [31:0] a, input logic [31:0] lo);
    return (a >= lo) && (a <= lo + 32'd11);
  endfunction

endpackage

// File: rtl/mem_addr_check.sv
// Combinational M-stage memory decode: address exception check, byte enables
// and lane-replicated store data for the DM/bridge.
module mem_addr_check
  import mips_defs::*;
#(
  parameter logic [31:0] DM_HI  = DM_HI_DEF,
  parameter logic [31:0] TC0_LO = TC0_LO_DEF,
  parameter logic [31:0] TC1_LO = TC1_LO_DEF
) (
  input  logic [3:0]  mem_op,
  input  logic [31:0] addr,
  input  logic [31:0] rt_data,
  input  logic [4:0]  exc_in,
  output logic [4:0]  exc_code,
  output logic [3:0]  be,
  output logic [31:0] wdata
);

  logic is_load, is_store, is_word, is_half;
  logic in_timer, range_bad, count_word, misalign, mem_fault;

  always_comb begin
    is_load    = (mem_op >= MOP_LW) && (mem_op <= MOP_LBU);
    is_store   = (mem_op >= MOP_SW) && (mem_op <= MOP_SB);
    is_word    = (mem_op == MOP_LW) || (mem_op == MOP_SW);
    is_half    = (mem_op == MOP_LH) || (mem_op == MOP_LHU) || (mem_op == MOP_SH);
    in_timer   = in_window(addr, TC0_LO) || in_window(addr, TC1_LO);
    range_bad  = (addr > DM_HI) && !in_timer;
    count_word = (addr == TC0_LO + 32'd8) || (addr == TC1_LO + 32'd8);
    misalign   = is_word ? (addr[1:0] != 2'b00) : (is_half && addr[0]);
    // Timer registers only accept whole-word accesses.
    mem_fault  = misalign || range_bad || (in_timer && !is_word);

    exc_code = exc_in;
    if (exc_in == EXC_NONE) begin
      if (is_load && mem_fault) begin
        exc_code = EXC_ADEL;
      end else if (is_store && (mem_fault || count_word)) begin
        exc_code = EXC_ADES;
      end
    end

    be    = 4'b0000;
    wdata = rt_data;
    case (mem_op)
      MOP_SW: begin
        if (exc_code == EXC_NONE) be = 4'b1111;
      end
      MOP_SH: begin
        wdata = {2{rt_data[15:0]}};
        if (exc_code == EXC_NONE) be = addr[1] ? 4'b1100 : 4'b0011;
      end
      MOP_SB: begin
        wdata = {4{rt_data[7:0]}};
        if (exc_code == EXC_NONE) be = 4'b0001 << addr[1:0];
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/pipe_reg_m.sv
// E->M pipeline register: latches E-stage results, decrements Tnew and feeds the
// M-stage memory decode whose exception code goes to CP0.
module pipe_reg_m
  import mips_defs::*;
#(
  parameter logic [31:0] DM_HI  = DM_HI_DEF,
  parameter logic [31:0] TC0_LO = TC0_LO_DEF,
  parameter logic [31:0] TC1_LO = TC1_LO_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic        flush,
  input  logic [31:0] Instr_E,
  input  logic [31:0] PC_E,
  input  logic [31:0] ALUOut_E,
  input  logic [31:0] RTData_E,
  input  logic [2:0]  Res_E,
  input  logic [4:0]  A3_E,
  input  logic [1:0]  Tnew_E,
  input  logic [3:0]  MemOp_E,
  input  logic [4:0]  ExcCode_E,
  input  logic        BD_E,
  output logic [31:0] Instr_M,
  output logic [31:0] PC_M,
  output logic [31:0] ALUOut_M,
  output logic [31:0] RTData_M,
  output logic [2:0]  Res_M,
  output logic [4:0]  A3_M,
  output logic [3:0]  MemOp_M,
  output logic        BD_M,
  output logic [1:0]  Tnew_M,
  output logic [4:0]  ExcCode_M,
  output logic [3:0]  BE_M,
  output logic [31:0] WData_M
);

  logic [4:0] exc_reg;

  // A flush keeps PC_E so CP0 still sees which PC the bubble replaced.
  always_ff @(posedge clk) begin
    if (reset) begin
      Instr_M  <= 32'd0;
      PC_M     <= 32'd0;
      ALUOut_M <= 32'd0;
      RTData_M <= 32'd0;
      Res_M    <= RES_NW;
      A3_M     <= 5'd0;
      MemOp_M  <= MOP_NONE;
      BD_M     <= 1'b0;
      Tnew_M   <= 2'd0;
      exc_reg  <= EXC_NONE;
    end else if (flush) begin
      Instr_M  <= 32'd0;
      PC_M     <= PC_E;
      ALUOut_M <= 32'd0;
      RTData_M <= 32'd0;
      Res_M    <= RES_NW;
      A3_M     <= 5'd0;
      MemOp_M  <= MOP_NONE;
      BD_M     <= 1'b0;
      Tnew_M   <= 2'd0;
      exc_reg  <= EXC_NONE;
    end else if (en) begin
      Instr_M  <= Instr_E;
      PC_M     <= PC_E;
      ALUOut_M <= ALUOut_E;
      RTData_M <= RTData_E;
      Res_M    <= Res_E;
      A3_M     <= A3_E;
      MemOp_M  <= MemOp_E;
      BD_M     <= BD_E;
      Tnew_M   <= tnew_step(Tnew_E);
      exc_reg  <= ExcCode_E;
    end
  end

  mem_addr_check #(
    .DM_HI  (DM_HI),
    .TC0_LO (TC0_LO),
    .TC1_LO (TC1_LO)
  ) u_mem_addr_check (
    .mem_op   (MemOp_M),
    .addr     (ALUOut_M),
    .rt_data  (RTData_M),
    .exc_in   (exc_reg),
    .exc_code (ExcCode_M),
    .be       (BE_M),
    .wdata    (WData_M)
  );

endmodule

// File: tb/tb_pipe_reg_m.sv
// Bench for pipe_reg_m: directed cases plus random traffic, scoreboarded against
// a behavioural model of the M-stage register and memory decode.
module tb_pipe_reg_m;

  localparam logic [31:0] M_DM_HI  = 32'h0000_2FFF;
  localparam logic [31:0] M_TC0_LO = 32'h0000_7F00;
  localparam logic [31:0] M_TC1_LO = 32'h0000_7F10;

  typedef struct packed {
    logic        rst, en, flush;
    logic [31:0] instr, pc, alu, rt;
    logic [2:0]  res;
    logic [4:0]  a3;
    logic [1:0]  tnew;
    logic [3:0]  memop;
    logic [4:0]  exc;
    logic        bd;
  } stim_t;

  typedef struct packed {
    logic [31:0] instr, pc, alu, rt;
    logic [2:0]  res;
    logic [4:0]  a3;
    logic [1:0]  tnew;
    logic [3:0]  memop;
    logic [4:0]  exc;
    logic        bd;
  } state_t;

  typedef struct packed {
    logic [31:0] instr, pc, alu, rt;
    logic [2:0]  res;
    logic [4:0]  a3;
    logic [3:0]  memop;
    logic        bd;
    logic [1:0]  tnew;
    logic [4:0]  exc;
    logic [3:0]  be;
    logic [31:0] wdata;
  } out_t;

  localparam int W = $bits(out_t);

  // clock / reset block
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, en, flush, BD_E, BD_M;
  logic [31:0] Instr_E, PC_E, ALUOut_E, RTData_E;
  logic [2:0]  Res_E, Res_M;
  logic [4:0]  A3_E, A3_M, ExcCode_E, ExcCode_M;
  logic [1:0]  Tnew_E, Tnew_M;
  logic [3:0]  MemOp_E, MemOp_M, BE_M;
  logic [31:0] Instr_M, PC_M, ALUOut_M, RTData_M, WData_M;

  pipe_reg_m dut (
    .clk(clk), .reset(reset), .en(en), .flush(flush),
    .Instr_E(Instr_E), .PC_E(PC_E), .ALUOut_E(ALUOut_E), .RTData_E(RTData_E),
    .Res_E(Res_E), .A3_E(A3_E), .Tnew_E(Tnew_E), .MemOp_E(MemOp_E),
    .ExcCode_E(ExcCode_E), .BD_E(BD_E),
    .Instr_M(Instr_M), .PC_M(PC_M), .ALUOut_M(ALUOut_M), .RTData_M(RTData_M),
    .Res_M(Res_M), .A3_M(A3_M), .MemOp_M(MemOp_M), .BD_M(BD_M),
    .Tnew_M(Tnew_M), .ExcCode_M(ExcCode_M), .BE_M(BE_M), .WData_M(WData_M)
  );

  logic [W-1:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;
  state_t m;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // reference model: register update rule, then memory decode from the held state
  task automatic model_clock(input stim_t s);
    if (s.rst) begin
      m = '0;
    end else if (s.flush) begin
      m = '0;
      m.pc = s.pc;
    end else if (s.en) begin
      m.instr = s.instr; m.pc = s.pc; m.alu = s.alu; m.rt = s.rt;
      m.res = s.res; m.a3 = s.a3; m.memop = s.memop; m.exc = s.exc; m.bd = s.bd;
      m.tnew = (s.tnew > 0) ? s.tnew - 2'd1 : 2'd0;
    end
  endtask

  function automatic out_t model_out(input state_t st);
    out_t o;
    longint unsigned a, bases[2];
    int size;
    bit is_ld, is_st, in_t, in_dm, cnt, bad;
    a = st.alu;
    bases[0] = M_TC0_LO;
    bases[1] = M_TC1_LO;
    is_ld = (st.memop >= 1) && (st.memop <= 5);
    is_st = (st.memop >= 6) && (st.memop <= 8);
    case (st.memop)
      4'd1, 4'd6:       size = 4;
      4'd2, 4'd3, 4'd7: size = 2;
      default:          size = 1;
    endcase
    in_t = 0;
    cnt  = 0;
    for (int i = 0; i < 2; i++) begin
      if (a >= bases[i] && a < bases[i] + 12) begin
        in_t = 1;
        if (a - bases[i] == 8) cnt = 1;
      end
    end
    in_dm = (a <= M_DM_HI);
    bad = ((a % size) != 0) || !(in_dm || in_t) || (in_t && size != 4);
    o = '0;
    o.instr = st.instr; o.pc = st.pc; o.alu = st.alu; o.rt = st.rt;
    o.res = st.res; o.a3 = st.a3; o.memop = st.memop; o.bd = st.bd; o.tnew = st.tnew;
    o.exc = st.exc;
    if (st.exc == 0) begin
      if (is_ld && bad) o.exc = 5'd4;
      else if (is_st && (bad || cnt)) o.exc = 5'd5;
    end
    o.be = 4'd0;
    if (is_st && o.exc == 0) o.be = 4'(((1 << size) - 1) << (a % 4));
    if (st.memop == 4'd8)      o.wdata = {4{st.rt[7:0]}};
    else if (st.memop == 4'd7) o.wdata = {2{st.rt[15:0]}};
    else                       o.wdata = st.rt;
    return o;
  endfunction

  // driver: apply one cycle of stimulus after the falling edge and queue the expected response
  task automatic step(input stim_t s);
    @(negedge clk);
    #1;
    reset = s.rst; en = s.en; flush = s.flush;
    Instr_E = s.instr; PC_E = s.pc; ALUOut_E = s.alu; RTData_E = s.rt;
    Res_E = s.res; A3_E = s.a3; Tnew_E = s.tnew; MemOp_E = s.memop;
    ExcCode_E = s.exc; BD_E = s.bd;
    model_clock(s);
    exp_q.push_back(model_out(m));
  endtask

  // wait until the stepped values are registered, for direct spot checks
  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  function automatic stim_t op(input logic [3:0] mop, input logic [31:0] addr,
                               input logic [31:0] rt, input logic [4:0] exc);
    stim_t s;
    s = '0;
    s.en = 1'b1; s.memop = mop; s.alu = addr; s.rt = rt; s.exc = exc;
    s.pc = 32'h0000_3000 + addr[7:0]; s.instr = 32'h8C00_0000 ^ addr;
    s.res = 3'd2; s.a3 = 5'd9; s.tnew = 2'd1;
    return s;
  endfunction

  function automatic logic [31:0] rand_addr();
    case ($urandom_range(0, 5))
      0:       return $urandom_range(0, 32'h2FFF);
      1:       return 32'h0000_2FF8 + $urandom_range(0, 16);
      2:       return 32'h0000_7EFC + $urandom_range(0, 19);
      3:       return 32'h0000_7F10 + $urandom_range(0, 15);
      4:       return 32'hFFFF_FFF0 + $urandom_range(0, 15);
      default: return $urandom;
    endcase
  endfunction

  function automatic stim_t rand_stim();
    stim_t s;
    s.rst   = ($urandom_range(0, 49) == 0);
    s.flush = ($urandom_range(0, 11) == 0);
    s.en    = ($urandom_range(0, 4) != 0);
    s.instr = $urandom; s.pc = $urandom; s.alu = rand_addr(); s.rt = $urandom;
    s.res   = 3'($urandom_range(0, 4));
    s.a3    = 5'($urandom);
    s.tnew  = 2'($urandom);
    s.memop = 4'($urandom_range(0, 9));
    s.exc   = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(1, 31)) : 5'd0;
    s.bd    = 1'($urandom);
    return s;
  endfunction

  // scoreboard monitor: one queued expectation per falling edge
  always @(negedge clk) begin : monitor
    out_t e;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check("Instr_M", Instr_M, e.instr);
      check("PC_M", PC_M, e.pc);
      check("ALUOut_M", ALUOut_M, e.alu);
      check("RTData_M", RTData_M, e.rt);
      check("Res_M", 32'(Res_M), 32'(e.res));
      check("A3_M", 32'(A3_M), 32'(e.a3));
      check("MemOp_M", 32'(MemOp_M), 32'(e.memop));
      check("BD_M", 32'(BD_M), 32'(e.bd));
      check("Tnew_M", 32'(Tnew_M), 32'(e.tnew));
      check("ExcCode_M", 32'(ExcCode_M), 32'(e.exc));
      check("BE_M", 32'(BE_M), 32'(e.be));
      check("WData_M", WData_M, e.wdata);
    end
  end

  initial begin
    stim_t s;
    m = '0;
    reset = 1'b0; en = 1'b0; flush = 1'b0;
    Instr_E = '0; PC_E = '0; ALUOut_E = '0; RTData_E = '0;
    Res_E = '0; A3_E = '0; Tnew_E = '0; MemOp_E = '0; ExcCode_E = '0; BD_E = 1'b0;

    // reset with every input nonzero
    s = op(4'd6, 32'h0000_1004, 32'hFFFF_FFFF, 5'd3);
    s.rst = 1'b1; s.flush = 1'b1; s.bd = 1'b1; s.tnew = 2'd3;
    step(s); settle();
    check("rst_PC_M", PC_M, 32'd0);
    check("rst_Instr_M", Instr_M, 32'd0);
    check("rst_ExcCode_M", 32'(ExcCode_M), 32'd0);
    check("rst_BE_M", 32'(BE_M), 32'd0);
    check("rst_WData_M", WData_M, 32'd0);
    check("rst_Tnew_M", 32'(Tnew_M), 32'd0);

    // aligned SW into DM
    s = op(4'd6, 32'h0000_1004, 32'hDEAD_BEEF, 5'd0);
    s.tnew = 2'd2;
    step(s); settle();
    check("sw_BE_M", 32'(BE_M), 32'hF);
    check("sw_WData_M", WData_M, 32'hDEAD_BEEF);
    check("sw_Tnew_M", 32'(Tnew_M), 32'd1);
    check("sw_ExcCode_M", 32'(ExcCode_M), 32'd0);

    // address exceptions and timer window access
    step(op(4'd1, 32'h0000_1002, 32'h1, 5'd0)); settle();
    check("lw_mis_exc", 32'(ExcCode_M), 32'd4);
    check("lw_mis_be", 32'(BE_M), 32'd0);
    step(op(4'd7, 32'h0000_3000, 32'h1, 5'd0)); settle();
    check("sh_range_exc", 32'(ExcCode_M), 32'd5);
    step(op(4'd6, 32'h0000_7F08, 32'h1, 5'd0)); settle();
    check("sw_count_exc", 32'(ExcCode_M), 32'd5);
    step(op(4'd1, 32'h0000_7F14, 32'h1, 5'd0)); settle();
    check("lw_timer_exc", 32'(ExcCode_M), 32'd0);
    step(op(4'd1, 32'h0000_2FFC, 32'h1, 5'd0)); settle();
    check("lw_dm_top_exc", 32'(ExcCode_M), 32'd0);
    step(op(4'd1, 32'hFFFF_FFFC, 32'h1, 5'd0)); settle();
    check("lw_neg_exc", 32'(ExcCode_M), 32'd4);

    // byte store lane select, then an earlier-stage exception taking precedence
    step(op(4'd8, 32'h0000_0103, 32'h1234_5678, 5'd0)); settle();
    check("sb_BE_M", 32'(BE_M), 32'h8);
    check("sb_WData_M", WData_M, 32'h7878_7878);
    step(op(4'd8, 32'h0000_0103, 32'h1234_5678, 5'd10)); settle();
    check("sb_exc_pass", 32'(ExcCode_M), 32'd10);
    check("sb_exc_be", 32'(BE_M), 32'd0);

    // flush wins over en; reset wins over flush
    s = op(4'd6, 32'h0000_0010, 32'h55, 5'd0);
    s.flush = 1'b1; s.pc = 32'h0000_3008; s.res = 3'd1; s.a3 = 5'd5;
    step(s); settle();
    check("flush_Res_M", 32'(Res_M), 32'd0);
    check("flush_A3_M", 32'(A3_M), 32'd0);
    check("flush_Instr_M", Instr_M, 32'd0);
    check("flush_PC_M", PC_M, 32'h0000_3008);
    s.rst = 1'b1;
    step(s); settle();
    check("rstflush_PC_M", PC_M, 32'd0);

    // hold for three cycles while inputs keep changing
    s = op(4'd1, 32'h0000_0010, 32'h77, 5'd0);
    s.pc = 32'h0000_0400; s.tnew = 2'd2;
    step(s); settle();
    for (int i = 0; i < 3; i++) begin
      s = rand_stim();
      s.rst = 1'b0; s.flush = 1'b0; s.en = 1'b0;
      step(s); settle();
      check("hold_Tnew_M", 32'(Tnew_M), 32'd1);
      check("hold_PC_M", PC_M, 32'h0000_0400);
      check("hold_ALUOut_M", ALUOut_M, 32'h0000_0010);
    end
    s = op(4'd0, 32'h0, 32'h0, 5'd0);
    s.tnew = 2'd0;
    step(s); settle();
    check("tnew_sat", 32'(Tnew_M), 32'd0);

    // random traffic
    for (int i = 0; i < 400; i++) step(rand_stim());

    for (int i = 0; i < 4 && exp_q.size() != 0; i++) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 32'd0);
    #2;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
